mux4to1_rr_stream: RTL
======================

// Module: mux4to1_rr_stream
// PURPOSE
//   Merges four valid/ready input streams into one output stream; the inverse of the 1-to-4 demux.
//   Round-robin arbitration picks a channel. A grant is held for a whole packet, from the first beat to the i_last beat.
//   One registered output stage. Sits upstream of a shared sink; the sink sees o_sel as the source tag.
// PARAMETERS
//   DATA_W   8   width of each data channel and of o_data
// PORTS
//   i_clk      in   1         single clock, all logic on rising edge
//   i_rst      in   1         synchronous reset, active-high
//   i_data_a   in   DATA_W    channel 0 data  (likewise i_data_b/_c/_d = ch 1/2/3)
//   i_valid_a  in   1         channel 0 valid (likewise _b/_c/_d)
//   i_last_a   in   1         channel 0 last beat of packet (likewise _b/_c/_d)
//   o_ready_a  out  1         channel 0 ready (likewise _b/_c/_d)
//   o_data     out  DATA_W    merged data
//   o_valid    out  1         merged valid
//   o_last     out  1         merged last
//   o_sel      out  2         source channel of current output beat (0..3)
//   i_ready    in   1         downstream ready
// BEHAVIOUR
//   Reset values:
//   - o_valid=0, o_data=0, o_last=0, o_sel=0.
//   - State IDLE, rr pointer ptr=3, so channel 0 has first priority.
//   Handshake:
//   - Beat transfers on a channel when valid & ready are both high in the same cycle; output side likewise with o_valid & i_ready.
//   - Input ready never depends on i_ready only through o_valid: load_en = !o_valid | i_ready.
//   - o_ready_k = load_en & (grant == k) & grant_valid. At most one o_ready_* high per cycle.
//   Latency and throughput:
//   - Accepted input beat appears on o_* on the next cycle.
//   - Full throughput of 1 beat/clk with i_ready held high.
//   - When o_valid=1 and i_ready=0, o_data, o_last and o_sel hold stable.
//   - A simultaneous drain and load in the same cycle is legal and loses no beat.
//   FSM:
//   - IDLE: grant = first valid channel searching ptr+1, ptr+2, ptr+3, ptr (mod 4). grant_valid = any valid.
//     - Beat accepted with last=0 -> LOCK, lock_ch = grant.
//     - Beat accepted with last=1 -> stay IDLE, ptr = grant.
//   - LOCK: grant = lock_ch only. Other channels are ignored even if valid.
//     - Accepted beat with last=1 -> IDLE, ptr = lock_ch.
//     - A locked channel that drops valid mid-packet stays locked; no other channel is granted.
//   Boundaries:
//   - All four valid: serve order follows ptr, one packet each, strict rotation.
//   - Single-beat packets (last=1 every beat) rotate every beat.
//   - Reset mid-packet: the packet is abandoned, the output register is cleared, state returns to IDLE, ptr=3.
// STRUCTURE
//   mux4to1_pkg:
//   - localparams NUM_CH=4, SEL_W=2.
//   - State encoding ST_IDLE=1'b0, ST_LOCK=1'b1.
//   Sub-module rr_pick4 (combinational):
//   - Inputs: 4-bit request, 2-bit ptr.
//   - Outputs: 2-bit grant, grant_valid.
//   Top level holds FSM, ptr, lock_ch, output register, ready decode.
// TESTING
//   1 Reset, then ch0 sends a 1-beat packet 0x11 (last=1), i_ready=1 -> o_valid next clk, o_data=0x11, o_sel=0, o_last=1.
//   2 All four channels valid, 1-beat packets 0xA0..0xD0 -> o_sel sequence 0,1,2,3,0 with no idle cycles.
//   3 ch1 3-beat packet while ch2 is also valid -> ch2 is held off (o_ready_c=0) until ch1 last beat; then o_sel=2.
//   4 i_ready=0 for 5 clks with o_valid=1 -> o_* stable, all o_ready_*=0; on release no beat is lost or duplicated.
//   5 ch3 locked and drops valid for 2 clks mid-packet while ch0 is valid -> no ch0 grant until ch3 last beat.
//   6 i_rst pulsed mid ch2 packet -> o_valid=0 next clk; next grant goes to lowest valid channel starting from ch0.

Source files
------------

// File: rtl/mux4to1_pkg.sv
// Shared constants and state encoding for the 4-to-1 round-robin stream merger.
package mux4to1_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

endpackage

// File: rtl/mux4to1_rr_stream_rr_pick4.sv
// Combinational round-robin picker: first requester after i_ptr, wrapping back to i_ptr itself.
module rr_pick4
    import mux4to1_pkg::*;
(
    input  logic [NUM_CH-1:0] i_req,
    input  logic [SEL_W-1:0]  i_ptr,
    output logic [SEL_W-1:0]  o_grant,
    output logic              o_grant_valid
);

    logic [SEL_W-1:0] idx;

    // Scan from the farthest candidate down to ptr+1 so the nearest requester wins last.
    always_comb begin
        o_grant       = i_ptr;
        o_grant_valid = 1'b0;
        idx           = i_ptr;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = i_ptr + SEL_W'(i);
            if (i_req[idx]) begin
                o_grant       = idx;
                o_grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4to1_rr_stream.sv
// Merges four valid/ready packet streams into one registered output; grants are held for a whole packet.
module mux4to1_rr_stream
    import mux4to1_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data_a,
    input  logic              i_valid_a,
    input  logic              i_last_a,
    output logic              o_ready_a,
    input  logic [DATA_W-1:0] i_data_b,
    input  logic              i_valid_b,
    input  logic              i_last_b,
    output logic              o_ready_b,
    input  logic [DATA_W-1:0] i_data_c,
    input  logic              i_valid_c,
    input  logic              i_last_c,
    output logic              o_ready_c,
    input  logic [DATA_W-1:0] i_data_d,
    input  logic              i_valid_d,
    input  logic              i_last_d,
    output logic              o_ready_d,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_last,
    output logic [SEL_W-1:0]  o_sel,
    input  logic              i_ready
);

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] lst;
    logic [DATA_W-1:0] dat [NUM_CH];

    assign req = {i_valid_d, i_valid_c, i_valid_b, i_valid_a};
    assign lst = {i_last_d, i_last_c, i_last_b, i_last_a};
    assign dat[0] = i_data_a;
    assign dat[1] = i_data_b;
    assign dat[2] = i_data_c;
    assign dat[3] = i_data_d;

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [SEL_W-1:0]  lock_ch_q, lock_ch_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic [SEL_W-1:0]  sel_q, sel_d;

    logic [SEL_W-1:0]  pick_grant;
    logic              pick_valid;
    logic [SEL_W-1:0]  grant;
    logic              grant_valid;
    logic              load_en;
    logic              accept;
    logic [NUM_CH-1:0] rdy_vec;

    rr_pick4 u_pick (
        .i_req         (req),
        .i_ptr         (ptr_q),
        .o_grant       (pick_grant),
        .o_grant_valid (pick_valid)
    );

    always_comb begin
        grant       = pick_grant;
        grant_valid = pick_valid;
        if (state_q == ST_LOCK) begin
            // A locked packet owns the output even while its source is momentarily idle.
            grant       = lock_ch_q;
            grant_valid = req[lock_ch_q];
        end
        load_en = !valid_q || i_ready;
        accept  = load_en && grant_valid;
        rdy_vec = '0;
        if (accept) begin
            rdy_vec[grant] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        lock_ch_d = lock_ch_q;
        valid_d   = valid_q;
        data_d    = data_q;
        last_d    = last_q;
        sel_d     = sel_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = dat[grant];
            last_d  = lst[grant];
            sel_d   = grant;
            if (lst[grant]) begin
                state_d = ST_IDLE;
                ptr_d   = grant;
            end else begin
                state_d   = ST_LOCK;
                lock_ch_d = grant;
            end
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= SEL_W'(NUM_CH - 1);
            lock_ch_q <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
            sel_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            lock_ch_q <= lock_ch_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            last_q    <= last_d;
            sel_q     <= sel_d;
        end
    end

    assign o_ready_a = rdy_vec[0];
    assign o_ready_b = rdy_vec[1];
    assign o_ready_c = rdy_vec[2];
    assign o_ready_d = rdy_vec[3];
    assign o_valid   = valid_q;
    assign o_data    = data_q;
    assign o_last    = last_q;
    assign o_sel     = sel_q;

endmodule
